// File: rtl/time_set_ctrl.sv
// Set-mode controller for the watch: debounces mode/up/down buttons and walks the
// user through hour, minute and second edit fields before loading the clock once.
module time_set_ctrl #(
  parameter int DEB_CYCLES    = 50000,
  parameter int BLINK_HALF    = 12500000,
  parameter int REPEAT_START  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_minute,
  input  logic [5:0] cur_second,
  output logic       edit_mode,
  output logic [1:0] field_sel,
  output logic [4:0] set_hour,
  output logic [5:0] set_minute,
  output logic [5:0] set_second,
  output logic       load,
  output logic       blink
);

  localparam int DW   = $clog2(DEB_CYCLES + 1);
  localparam int BW   = $clog2(BLINK_HALF + 1);
  localparam int RMAX = (REPEAT_START > REPEAT_PERIOD) ? REPEAT_START : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_HALF - 1);
  localparam logic [RW-1:0] START_LAST  = RW'(REPEAT_START - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  localparam int MODE = 0;
  localparam int UP   = 1;
  localparam int DOWN = 2;

  localparam logic [2:0] RUN    = 3'd0;
  localparam logic [2:0] SET_H  = 3'd1;
  localparam logic [2:0] SET_M  = 3'd2;
  localparam logic [2:0] SET_S  = 3'd3;
  localparam logic [2:0] COMMIT = 3'd4;

  logic [2:0]    raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    stable;
  logic [2:0]    stable_d;
  logic [2:0]    press;
  logic [DW-1:0] deb_cnt [3];

  logic [2:0]    state;
  logic [2:0]    state_next;
  logic          in_set;
  logic          next_in_set;

  logic [RW-1:0] rep_cnt;
  logic          rep_started;
  logic          rep_active;
  logic          rep_fire;
  logic          both_held;
  logic          step_up;
  logic          step_down;
  logic          step_any;

  logic [BW-1:0] blink_cnt;

  function automatic logic [4:0] wrap_hour(input logic [4:0] v, input logic up);
    if (up) return (v == 5'd23) ? 5'd0 : v + 5'd1;
    return (v == 5'd0) ? 5'd23 : v - 5'd1;
  endfunction

  function automatic logic [5:0] wrap_sixty(input logic [5:0] v, input logic up);
    if (up) return (v == 6'd59) ? 6'd0 : v + 6'd1;
    return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

  assign raw = {btn_down, btn_up, btn_mode};

  // A level is accepted only after it differs from the stable level for DEB_CYCLES edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_d <= '0;
      press    <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_d <= stable;
      press    <= stable & ~stable_d;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          stable[i]  <= ~stable[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign in_set      = (state == SET_H) || (state == SET_M) || (state == SET_S);
  assign next_in_set = (state_next == SET_H) || (state_next == SET_M) || (state_next == SET_S);
  assign both_held   = stable[UP] & stable[DOWN];
  assign rep_active  = in_set & (stable[UP] ^ stable[DOWN]);
  assign rep_fire    = rep_active & (rep_cnt == (rep_started ? PERIOD_LAST : START_LAST));

  // Mode wins over a simultaneous up/down event; holding both buttons does nothing.
  assign step_up   = in_set & ~press[MODE] & ~both_held & (press[UP]   | (rep_fire & stable[UP]));
  assign step_down = in_set & ~press[MODE] & ~both_held & (press[DOWN] | (rep_fire & stable[DOWN]));
  assign step_any  = step_up | step_down;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt     <= '0;
      rep_started <= 1'b0;
    end else if (!rep_active) begin
      rep_cnt     <= '0;
      rep_started <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt     <= '0;
      rep_started <= 1'b1;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (press[MODE]) state_next = SET_H;
      SET_H:   if (press[MODE]) state_next = SET_M;
      SET_M:   if (press[MODE]) state_next = SET_S;
      SET_S:   if (press[MODE]) state_next = COMMIT;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      set_hour   <= '0;
      set_minute <= '0;
      set_second <= '0;
    end else begin
      state <= state_next;
      case (state)
        RUN: if (press[MODE]) begin
          set_hour   <= cur_hour;
          set_minute <= cur_minute;
          set_second <= cur_second;
        end
        SET_H:   if (step_any) set_hour   <= wrap_hour(set_hour, step_up);
        SET_M:   if (step_any) set_minute <= wrap_sixty(set_minute, step_up);
        SET_S:   if (step_any) set_second <= wrap_sixty(set_second, step_up);
        default: ;
      endcase
    end
  end

  // The field is kept visible on entry and while being adjusted, then flashes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink     <= 1'b1;
      blink_cnt <= '0;
    end else if (!next_in_set || (state_next != state) || step_any) begin
      blink     <= 1'b1;
      blink_cnt <= '0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink     <= ~blink;
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_comb begin
    field_sel = 2'd0;
    case (state)
      SET_H:   field_sel = 2'd1;
      SET_M:   field_sel = 2'd2;
      SET_S:   field_sel = 2'd3;
      default: field_sel = 2'd0;
    endcase
  end

  assign edit_mode = in_set;
  assign load      = (state == COMMIT);

endmodule
